stopwatch_ctrl: RTL and testbench

Control front-end for the light-timer stopwatch datapath (BCD mm:ss:hh counter with a single-cycle start/stop toggle input and a clear input). Debounces two raw push-buttons, sequences the stopwatch through idle/run/pause/lap states, and issues the one-cycle toggle and clear pulses to the counter. Captures a lap snapshot of the counter's 24-bit BCD value and selects what the 7-segment display path shows.

---
 rtl/stopwatch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: button debounce, idle/run/pause/lap sequencing,
// counter toggle/clear pulses and lap snapshot. Lap feature enabled by SWCTRL_LAP_EN.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [23:0] time_in,
  output logic        run_toggle,
  output logic        timer_clr,
  output logic [23:0] disp_out,
  output logic        running,
  output logic        lap_active,
  output logic [1:0]  state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
`ifdef SWCTRL_LAP_EN
  localparam logic [1:0] ST_LAP   = 2'b11;
`endif
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button index 0 = start/stop, 1 = lap/reset.
  logic [1:0]            btn_raw;
  logic [1:0]            sync1_q, sync2_q, db_q, db_dly_q, ev_q;
  logic [1:0][DB_W-1:0]  cnt_q;
  logic                  ev_ss, ev_lr;

  assign btn_raw = {btn_lr, btn_ss};
  assign ev_ss   = ev_q[0];
  assign ev_lr   = ev_q[1];

  // Synchronize, debounce, and flag debounced rising edges one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      ev_q     <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      ev_q     <= db_q & ~db_dly_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          db_q[i]  <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  logic [1:0] state_q, state_d;
  logic       run_toggle_q, run_toggle_d;
  logic       timer_clr_q, timer_clr_d;
  logic       running_q, running_d;
`ifdef SWCTRL_LAP_EN
  logic [23:0] lap_q, lap_d;
  logic        lap_active_q, lap_active_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      run_toggle_q <= 1'b0;
      timer_clr_q  <= 1'b0;
      running_q    <= 1'b0;
`ifdef SWCTRL_LAP_EN
      lap_q        <= '0;
      lap_active_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      run_toggle_q <= run_toggle_d;
      timer_clr_q  <= timer_clr_d;
      running_q    <= running_d;
`ifdef SWCTRL_LAP_EN
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
`endif
    end
  end

  // Start/stop has priority; a coincident lap/reset event is dropped.
  always_comb begin
    state_d      = state_q;
    run_toggle_d = 1'b0;
    timer_clr_d  = 1'b0;
`ifdef SWCTRL_LAP_EN
    lap_d        = lap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ev_ss) begin
          state_d      = ST_RUN;
          run_toggle_d = 1'b1;
        end else if (ev_lr) begin
          timer_clr_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (ev_ss) begin
          state_d      = ST_PAUSE;
          run_toggle_d = 1'b1;
        end
`ifdef SWCTRL_LAP_EN
        else if (ev_lr) begin
          state_d      = ST_LAP;
          lap_d        = time_in;
        end
`endif
      end
`ifdef SWCTRL_LAP_EN
      ST_LAP: begin
        if (ev_ss) begin
          state_d      = ST_PAUSE;
          run_toggle_d = 1'b1;
        end else if (ev_lr) begin
          state_d      = ST_RUN;
        end
      end
`endif
      ST_PAUSE: begin
        if (ev_ss) begin
          state_d      = ST_RUN;
          run_toggle_d = 1'b1;
        end else if (ev_lr) begin
          state_d      = ST_IDLE;
          timer_clr_d  = 1'b1;
`ifdef SWCTRL_LAP_EN
          lap_d        = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef SWCTRL_LAP_EN
    running_d    = (state_d == ST_RUN) || (state_d == ST_LAP);
    lap_active_d = (state_d == ST_LAP);
`else
    running_d    = (state_d == ST_RUN);
`endif
  end

  assign state      = state_q;
  assign run_toggle = run_toggle_q;
  assign timer_clr  = timer_clr_q;
  assign running    = running_q;
`ifdef SWCTRL_LAP_EN
  assign lap_active = lap_active_q;
  assign disp_out   = lap_active_q ? lap_q : time_in;
`else
  assign lap_active = 1'b0;
  assign disp_out   = time_in;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4; covers both
// SWCTRL_LAP_EN builds.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_ss, btn_lr;
  logic [23:0] time_in;
  logic        run_toggle, timer_clr, running, lap_active;
  logic [23:0] disp_out;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  int tog_cnt = 0;
  int clr_cnt = 0;
  int both_cnt = 0;
  int multi_cnt = 0;
  logic prev_tog = 1'b0;
  logic prev_clr = 1'b0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(4)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .time_in(time_in), .run_toggle(run_toggle), .timer_clr(timer_clr),
    .disp_out(disp_out), .running(running), .lap_active(lap_active),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally pulse activity.
  task automatic tick();
    @(negedge clk);
    if (run_toggle) tog_cnt++;
    if (timer_clr) clr_cnt++;
    if (run_toggle && timer_clr) both_cnt++;
    if ((run_toggle && prev_tog) || (timer_clr && prev_clr)) multi_cnt++;
    prev_tog = run_toggle;
    prev_clr = timer_clr;
  endtask

  task automatic press(input logic ss, input logic lr);
    btn_ss = ss;
    btn_lr = lr;
    repeat (10) tick();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (10) tick();
  endtask

  int first;
  int tog_base, clr_base;

  initial begin
    reset   = 1'b1;
    btn_ss  = 1'b0;
    btn_lr  = 1'b0;
    time_in = 24'h111111;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_state", 24'(state), 24'h0);
    chk("rst_toggle", 24'(run_toggle), 24'h0);
    chk("rst_clr", 24'(timer_clr), 24'h0);
    chk("rst_running", 24'(running), 24'h0);
    chk("rst_lap_active", 24'(lap_active), 24'h0);
    chk("rst_disp", disp_out, 24'h111111);

    // 3-cycle glitch must not qualify
    btn_ss = 1'b1;
    repeat (3) tick();
    btn_ss = 1'b0;
    repeat (12) tick();
    chk("glitch_toggles", 24'(tog_cnt), 24'h0);
    chk("glitch_state", 24'(state), 24'h0);

    // Held press: toggle appears 8 cycles after press
    first = -1;
    btn_ss = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (run_toggle && first < 0) first = k;
    end
    btn_ss = 1'b0;
    repeat (10) tick();
    chk("press_first_cycle", 24'(first), 24'd8);
    chk("press_toggles", 24'(tog_cnt), 24'd1);
    chk("press_state", 24'(state), 24'h1);
    chk("press_running", 24'(running), 24'h1);

    time_in = 24'h012345;
    press(1'b0, 1'b1);
`ifdef SWCTRL_LAP_EN
    chk("lap_state", 24'(state), 24'h3);
    chk("lap_active", 24'(lap_active), 24'h1);
    chk("lap_running", 24'(running), 24'h1);
    chk("lap_disp", disp_out, 24'h012345);
    time_in = 24'h012399;
    tick();
    chk("lap_disp_hold", disp_out, 24'h012345);
    press(1'b0, 1'b1);
    chk("unlap_state", 24'(state), 24'h1);
    chk("unlap_active", 24'(lap_active), 24'h0);
    chk("unlap_disp", disp_out, 24'h012399);
`else
    chk("nolap_state", 24'(state), 24'h1);
    chk("nolap_active", 24'(lap_active), 24'h0);
    time_in = 24'h012399;
    tick();
    chk("nolap_disp", disp_out, 24'h012399);
`endif
    chk("lap_no_clr", 24'(clr_cnt), 24'h0);
    chk("lap_no_toggle", 24'(tog_cnt), 24'd1);

    // RUN -> PAUSE -> IDLE with clear
    press(1'b1, 1'b0);
    chk("pause_state", 24'(state), 24'h2);
    chk("pause_running", 24'(running), 24'h0);
    chk("pause_toggles", 24'(tog_cnt), 24'd2);
    press(1'b0, 1'b1);
    chk("clear_state", 24'(state), 24'h0);
    chk("clear_pulses", 24'(clr_cnt), 24'd1);
    time_in = 24'h000000;
    tick();
    chk("clear_disp", disp_out, 24'h000000);

    // Lap/reset in IDLE clears and stays
    press(1'b0, 1'b1);
    chk("idle_lr_state", 24'(state), 24'h0);
    chk("idle_lr_clr", 24'(clr_cnt), 24'd2);

    // Simultaneous events from RUN: start/stop wins
    press(1'b1, 1'b0);
    chk("rerun_state", 24'(state), 24'h1);
    tog_base = tog_cnt;
    clr_base = clr_cnt;
    press(1'b1, 1'b1);
    chk("both_state", 24'(state), 24'h2);
    chk("both_toggle", 24'(tog_cnt - tog_base), 24'd1);
    chk("both_no_clr", 24'(clr_cnt - clr_base), 24'd0);
    chk("both_no_lap", 24'(lap_active), 24'h0);

    // Reset mid-debounce (from LAP when present)
    press(1'b1, 1'b0);
    chk("resume_state", 24'(state), 24'h1);
`ifdef SWCTRL_LAP_EN
    time_in = 24'h045600;
    press(1'b0, 1'b1);
    chk("lap2_state", 24'(state), 24'h3);
`endif
    tog_base = tog_cnt;
    btn_ss = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("arst_state", 24'(state), 24'h0);
    chk("arst_running", 24'(running), 24'h0);
    chk("arst_lap_active", 24'(lap_active), 24'h0);
    chk("arst_toggle", 24'(run_toggle), 24'h0);
    chk("arst_disp", disp_out, time_in);
    tick();
    btn_ss = 1'b0;
    reset = 1'b0;
    repeat (15) tick();
    chk("post_rst_toggles", 24'(tog_cnt - tog_base), 24'd0);
    chk("post_rst_state", 24'(state), 24'h0);

    chk("pulse_overlap", 24'(both_cnt), 24'd0);
    chk("pulse_multicycle", 24'(multi_cnt), 24'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
